// File: rtl/nvdla_csc_wl_enc.sv
// ---------------------------------------------------------------------------
// nvdla_csc_wl_enc
// Sparse weight encoder for the CSC weight path.
//
// Each input atom of ATOMC elements gives two results. The first is a nonzero
// mask. The second is the atom's nonzero elements, compacted into a dense
// stream of ATOMC-element data words. A partial word (the residue) is carried
// across the atoms of one kernel group. At group end the residue is flushed,
// zero-padded, with dat_last set.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   in_pvld/in_prdy/in_data/in_last  : dense input atom channel
//   mask_pvld/mask_prdy/mask_data    : per-atom nonzero mask channel
//   dat_pvld/dat_prdy/dat_data/
//   dat_last                         : packed data word channel
//
// Optional build macro NVDLA_WL_ENC_STAT_EN adds the following ports:
//   stat_clr      : synchronous clear for both counters
//   stat_nz_cnt   : saturating count of nonzero elements encoded
//   stat_word_cnt : saturating count of data words handed off
// ---------------------------------------------------------------------------
module nvdla_csc_wl_enc #(
    parameter int ATOMC = 8,
    parameter int BPE   = 8,
    parameter int CNTW  = 4
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [ATOMC*BPE-1:0]   in_data,
    input  logic                   in_last,
    output logic                   mask_pvld,
    input  logic                   mask_prdy,
    output logic [ATOMC-1:0]       mask_data,
    output logic                   dat_pvld,
    input  logic                   dat_prdy,
    output logic [ATOMC*BPE-1:0]   dat_data,
    output logic                   dat_last
`ifdef NVDLA_WL_ENC_STAT_EN
    ,
    input  logic                   stat_clr,
    output logic [31:0]            stat_nz_cnt,
    output logic [31:0]            stat_word_cnt
`endif
);

    localparam logic [CNTW-1:0] ATOMC_C = CNTW'(ATOMC);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t                   state_r;
    logic                     s1_vld_r;
    logic [ATOMC*BPE-1:0]     s1_data_r;
    logic [ATOMC-1:0]         s1_mask_r;
    logic [ATOMC*CNTW-1:0]    s1_pfx_r;
    logic                     s1_last_r;
    logic [CNTW-1:0]          res_cnt_r;
    logic [ATOMC*BPE-1:0]     res_data_r;

    logic [ATOMC-1:0]         in_mask_s;
    logic [ATOMC*CNTW-1:0]    in_pfx_s;
    logic [CNTW-1:0]          pfx_acc_s;
    logic [CNTW-1:0]          idx_s;
    logic [2*ATOMC*BPE-1:0]   merge_s;
    logic [CNTW-1:0]          n_s;
    logic [CNTW-1:0]          t_s;
    logic                     mask_free_s;
    logic                     dat_free_s;
    logic                     s1_adv_s;

    // Handshake and stall decisions. Both channels must be able to accept before S1 moves.
    always_comb begin
        mask_free_s = !mask_pvld || mask_prdy;
        dat_free_s  = !dat_pvld || dat_prdy;
        s1_adv_s    = s1_vld_r && (state_r == ST_RUN) && mask_free_s && dat_free_s;
        in_prdy     = !s1_vld_r || s1_adv_s;
    end

    // Per-element nonzero flags and exclusive prefix sums (the slot offset of each nonzero element).
    always_comb begin
        in_mask_s = {ATOMC{1'b0}};
        in_pfx_s  = {(ATOMC*CNTW){1'b0}};
        pfx_acc_s = {CNTW{1'b0}};
        for (int i = 0; i < ATOMC; i++) begin
            in_mask_s[i]              = |in_data[i*BPE +: BPE];
            in_pfx_s[i*CNTW +: CNTW]  = pfx_acc_s;
            pfx_acc_s                 = pfx_acc_s + {{(CNTW-1){1'b0}}, in_mask_s[i]};
        end
    end

    // Append the compacted S1 elements to the residue at slot r. The residue is zero above r,
    // so every slot past t stays zero and the word comes out zero-padded.
    always_comb begin
        merge_s = {{(ATOMC*BPE){1'b0}}, res_data_r};
        idx_s   = {CNTW{1'b0}};
        for (int i = 0; i < ATOMC; i++) begin
            idx_s = res_cnt_r + s1_pfx_r[i*CNTW +: CNTW];
            merge_s[idx_s*BPE +: BPE] = s1_mask_r[i] ? s1_data_r[i*BPE +: BPE]
                                                     : merge_s[idx_s*BPE +: BPE];
        end
        n_s = s1_pfx_r[(ATOMC-1)*CNTW +: CNTW] + {{(CNTW-1){1'b0}}, s1_mask_r[ATOMC-1]};
        t_s = res_cnt_r + n_s;
    end

    // S1 pipeline register: holds the atom with its mask and prefix sums until it advances.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= {(ATOMC*BPE){1'b0}};
            s1_mask_r <= {ATOMC{1'b0}};
            s1_pfx_r  <= {(ATOMC*CNTW){1'b0}};
            s1_last_r <= 1'b0;
        end else if (in_pvld && in_prdy) begin
            s1_vld_r  <= 1'b1;
            s1_data_r <= in_data;
            s1_mask_r <= in_mask_s;
            s1_pfx_r  <= in_pfx_s;
            s1_last_r <= in_last;
        end else if (s1_adv_s) begin
            s1_vld_r  <= 1'b0;
        end
    end

    // Encoder FSM: residue bookkeeping plus registered mask and data outputs.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r    <= ST_RUN;
            res_cnt_r  <= {CNTW{1'b0}};
            res_data_r <= {(ATOMC*BPE){1'b0}};
            mask_pvld  <= 1'b0;
            mask_data  <= {ATOMC{1'b0}};
            dat_pvld   <= 1'b0;
            dat_data   <= {(ATOMC*BPE){1'b0}};
            dat_last   <= 1'b0;
        end else begin
            if (mask_prdy) begin
                mask_pvld <= 1'b0;
            end
            if (dat_prdy) begin
                dat_pvld <= 1'b0;
            end
            if (s1_adv_s) begin
                mask_pvld <= 1'b1;
                mask_data <= s1_mask_r;
                if (s1_last_r && (t_s > ATOMC_C)) begin
                    // The group overflows one word, so the tail goes out on the next cycle.
                    dat_pvld   <= 1'b1;
                    dat_data   <= merge_s[ATOMC*BPE-1:0];
                    dat_last   <= 1'b0;
                    res_data_r <= merge_s[2*ATOMC*BPE-1:ATOMC*BPE];
                    res_cnt_r  <= t_s - ATOMC_C;
                    state_r    <= ST_FLUSH;
                end else if (s1_last_r) begin
                    // Includes t==0: an all-zero word still closes the group.
                    dat_pvld   <= 1'b1;
                    dat_data   <= merge_s[ATOMC*BPE-1:0];
                    dat_last   <= 1'b1;
                    res_data_r <= {(ATOMC*BPE){1'b0}};
                    res_cnt_r  <= {CNTW{1'b0}};
                end else if (t_s >= ATOMC_C) begin
                    dat_pvld   <= 1'b1;
                    dat_data   <= merge_s[ATOMC*BPE-1:0];
                    dat_last   <= 1'b0;
                    res_data_r <= merge_s[2*ATOMC*BPE-1:ATOMC*BPE];
                    res_cnt_r  <= t_s - ATOMC_C;
                end else begin
                    res_data_r <= merge_s[ATOMC*BPE-1:0];
                    res_cnt_r  <= t_s;
                end
            end else if ((state_r == ST_FLUSH) && dat_free_s) begin
                dat_pvld   <= 1'b1;
                dat_data   <= res_data_r;
                dat_last   <= 1'b1;
                res_data_r <= {(ATOMC*BPE){1'b0}};
                res_cnt_r  <= {CNTW{1'b0}};
                state_r    <= ST_RUN;
            end
        end
    end

`ifdef NVDLA_WL_ENC_STAT_EN
    logic [32:0] nz_sum_s;

    // Widened sum so that a carry out of bit 31 marks saturation.
    always_comb begin
        nz_sum_s = {1'b0, stat_nz_cnt} + {{(33-CNTW){1'b0}}, n_s};
    end

    // Saturating statistics counters. The clear takes priority over any increment.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stat_nz_cnt   <= 32'd0;
            stat_word_cnt <= 32'd0;
        end else if (stat_clr) begin
            stat_nz_cnt   <= 32'd0;
            stat_word_cnt <= 32'd0;
        end else begin
            if (s1_adv_s) begin
                stat_nz_cnt <= nz_sum_s[32] ? 32'hFFFF_FFFF : nz_sum_s[31:0];
            end
            if (dat_pvld && dat_prdy && (stat_word_cnt != 32'hFFFF_FFFF)) begin
                stat_word_cnt <= stat_word_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nvdla_csc_wl_enc.sv
module tb_nvdla_csc_wl_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_pvld;
    logic        in_prdy;
    logic [63:0] in_data;
    logic        in_last;
    logic        mask_pvld;
    logic        mask_prdy;
    logic [7:0]  mask_data;
    logic        dat_pvld;
    logic        dat_prdy;
    logic [63:0] dat_data;
    logic        dat_last;
`ifdef NVDLA_WL_ENC_STAT_EN
    logic        stat_clr;
    logic [31:0] stat_nz_cnt;
    logic [31:0] stat_word_cnt;
`endif

    nvdla_csc_wl_enc #(.ATOMC(8), .BPE(8), .CNTW(4)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_data         (in_data),
        .in_last         (in_last),
        .mask_pvld       (mask_pvld),
        .mask_prdy       (mask_prdy),
        .mask_data       (mask_data),
        .dat_pvld        (dat_pvld),
        .dat_prdy        (dat_prdy),
        .dat_data        (dat_data),
        .dat_last        (dat_last)
`ifdef NVDLA_WL_ENC_STAT_EN
        ,
        .stat_clr        (stat_clr),
        .stat_nz_cnt     (stat_nz_cnt),
        .stat_word_cnt   (stat_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc;
    int prdy_low = 0;
    int hold_viol = 0;

    logic [7:0]  mask_q[$];
    int          mask_cyc_q[$];
    logic [64:0] dat_q[$];
    int          dat_cyc_q[$];

    logic        mask_stall_r = 1'b0;
    logic [7:0]  mask_held_r = 8'h00;
    logic        dat_stall_r = 1'b0;
    logic [64:0] dat_held_r = 65'd0;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mask_stall_r <= 1'b0;
            dat_stall_r  <= 1'b0;
        end else begin
            if (mask_pvld && mask_prdy) begin
                mask_q.push_back(mask_data);
                mask_cyc_q.push_back(cyc);
            end
            if (dat_pvld && dat_prdy) begin
                dat_q.push_back({dat_last, dat_data});
                dat_cyc_q.push_back(cyc);
            end
            if (mask_stall_r && (!mask_pvld || mask_data !== mask_held_r))
                hold_viol <= hold_viol + 1;
            if (dat_stall_r && (!dat_pvld || {dat_last, dat_data} !== dat_held_r))
                hold_viol <= hold_viol + 1;
            mask_stall_r <= mask_pvld && !mask_prdy;
            mask_held_r  <= mask_data;
            dat_stall_r  <= dat_pvld && !dat_prdy;
            dat_held_r   <= {dat_last, dat_data};
            if (!in_prdy) prdy_low <= prdy_low + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        logic done;
        done = 1'b0;
        in_pvld = 1'b1;
        in_data = d;
        in_last = l;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_prdy) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_pvld = 1'b0;
        in_data = 64'd0;
        in_last = 1'b0;
        if (!done) check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_prdy"},   64'(in_prdy),   64'd1);
        check({tag, "_mask_pvld"}, 64'(mask_pvld), 64'd0);
        check({tag, "_dat_pvld"},  64'(dat_pvld),  64'd0);
        check({tag, "_mask_data"}, 64'(mask_data), 64'd0);
        check({tag, "_dat_data"},  dat_data,       64'd0);
        check({tag, "_dat_last"},  64'(dat_last),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mb;
        int db;
        int pl;
        int acc_b;
        logic [63:0] exp_w[16];
        logic [7:0]  bv;

        rst_n     = 1'b0;
        in_pvld   = 1'b0;
        in_data   = 64'd0;
        in_last   = 1'b0;
        mask_prdy = 1'b1;
        dat_prdy  = 1'b1;
`ifdef NVDLA_WL_ENC_STAT_EN
        stat_clr  = 1'b0;
`endif
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Test 1: fully dense single-atom group.
        mb = mask_q.size(); db = dat_q.size();
        send(64'h0807060504030201, 1'b1);
        tick(6);
        check("t1_mask_cnt", 64'(mask_q.size() - mb), 64'd1);
        check("t1_dat_cnt",  64'(dat_q.size() - db),  64'd1);
        if (mask_q.size() > mb) begin
            check("t1_mask",     64'(mask_q[mb]), 64'hFF);
            check("t1_mask_lat", 64'(mask_cyc_q[mb] - acc_cyc), 64'd2);
        end
        if (dat_q.size() > db) begin
            check("t1_dat",      dat_q[db][63:0], 64'h0807060504030201);
            check("t1_last",     64'(dat_q[db][64]), 64'd1);
            check("t1_dat_lat",  64'(dat_cyc_q[db] - acc_cyc), 64'd2);
        end

        // Test 2: sparse atom, then an all-zero last atom.
        mb = mask_q.size(); db = dat_q.size();
        send(64'h3300_0000_2200_0011, 1'b0);
        send(64'h0, 1'b1);
        tick(6);
        check("t2_mask_cnt", 64'(mask_q.size() - mb), 64'd2);
        check("t2_dat_cnt",  64'(dat_q.size() - db),  64'd1);
        if (mask_q.size() > mb + 1) begin
            check("t2_mask0", 64'(mask_q[mb]),   64'h89);
            check("t2_mask1", 64'(mask_q[mb+1]), 64'h00);
        end
        if (dat_q.size() > db) begin
            check("t2_dat",  dat_q[db][63:0], 64'h0000_0000_0033_2211);
            check("t2_last", 64'(dat_q[db][64]), 64'd1);
        end

        // Test 3: group overflows one word (FLUSH), with a following atom queued behind it.
        mb = mask_q.size(); db = dat_q.size(); pl = prdy_low;
        send(64'h00A6A5A4A3A2A1A0, 1'b0);
        send(64'hB7B6B5B4B3B2B1B0, 1'b1);
        acc_b = acc_cyc;
        send(64'hC7C6C5C4C3C2C1C0, 1'b1);
        tick(8);
        check("t3_prdy_low", 64'(prdy_low - pl), 64'd1);
        check("t3_mask_cnt", 64'(mask_q.size() - mb), 64'd3);
        check("t3_dat_cnt",  64'(dat_q.size() - db),  64'd3);
        if (mask_q.size() > mb + 2) begin
            check("t3_mask0", 64'(mask_q[mb]),   64'h7F);
            check("t3_mask1", 64'(mask_q[mb+1]), 64'hFF);
            check("t3_mask2", 64'(mask_q[mb+2]), 64'hFF);
        end
        if (dat_q.size() > db + 2) begin
            check("t3_w1",     dat_q[db][63:0],     64'hB0A6A5A4A3A2A1A0);
            check("t3_w1last", 64'(dat_q[db][64]),  64'd0);
            check("t3_w1lat",  64'(dat_cyc_q[db] - acc_b), 64'd2);
            check("t3_w2",     dat_q[db+1][63:0],   64'h00B7B6B5B4B3B2B1);
            check("t3_w2last", 64'(dat_q[db+1][64]), 64'd1);
            check("t3_w3",     dat_q[db+2][63:0],   64'hC7C6C5C4C3C2C1C0);
            check("t3_w3last", 64'(dat_q[db+2][64]), 64'd1);
        end

        // Test 4: single all-zero group.
        mb = mask_q.size(); db = dat_q.size();
        send(64'h0, 1'b1);
        tick(6);
        check("t4_mask_cnt", 64'(mask_q.size() - mb), 64'd1);
        check("t4_dat_cnt",  64'(dat_q.size() - db),  64'd1);
        if (mask_q.size() > mb) check("t4_mask", 64'(mask_q[mb]), 64'h00);
        if (dat_q.size() > db) begin
            check("t4_dat",  dat_q[db][63:0],   64'h0);
            check("t4_last", 64'(dat_q[db][64]), 64'd1);
        end

        // Test 5: 16 dense atoms with data backpressure mid-stream.
        mb = mask_q.size(); db = dat_q.size(); pl = prdy_low;
        for (int i = 0; i < 16; i++) begin
            bv = 8'h10 + 8'(i);
            exp_w[i] = {8{bv}};
        end
        fork
            begin
                for (int i = 0; i < 16; i++) send(exp_w[i], (i % 4) == 3);
            end
            begin
                tick(6);
                dat_prdy = 1'b0;
                tick(5);
                dat_prdy = 1'b1;
            end
        join
        tick(10);
        check("t5_prdy_drop", 64'(prdy_low - pl > 0), 64'd1);
        check("t5_hold",      64'(hold_viol), 64'd0);
        check("t5_mask_cnt",  64'(mask_q.size() - mb), 64'd16);
        check("t5_dat_cnt",   64'(dat_q.size() - db),  64'd16);
        if (mask_q.size() - mb == 16 && dat_q.size() - db == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("t5_mask%0d", i), 64'(mask_q[mb+i]), 64'hFF);
                check($sformatf("t5_w%0d", i), dat_q[db+i][63:0], exp_w[i]);
                check($sformatf("t5_last%0d", i), 64'(dat_q[db+i][64]), 64'((i % 4) == 3));
            end
        end

        // Test 6: reset while a residue of 3 is pending.
        send(64'h0000_0044_0033_0022, 1'b0);
        tick(4);
        rst_n = 1'b0;
        tick(2);
        check_reset_outputs("t6_rst");
        rst_n = 1'b1;
        tick(1);
        mb = mask_q.size(); db = dat_q.size();
        send(64'h1122334455667788, 1'b1);
        tick(6);
        check("t6_mask_cnt", 64'(mask_q.size() - mb), 64'd1);
        check("t6_dat_cnt",  64'(dat_q.size() - db),  64'd1);
        if (mask_q.size() > mb) check("t6_mask", 64'(mask_q[mb]), 64'hFF);
        if (dat_q.size() > db) begin
            check("t6_dat",  dat_q[db][63:0],   64'h1122334455667788);
            check("t6_last", 64'(dat_q[db][64]), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
